// File: rtl/complex_mul_pkg.sv
// complex_mul_pkg: shared state encoding, select/op constants and watchdog sizing.
package complex_mul_pkg;
  typedef enum logic [3:0] {
    IDLE, LOAD, AC_S, AC_W, BD_S, BD_W, AD_S, AD_W, BC_S, BC_W, DONE
  } state_t;
  localparam logic SEL_HI  = 1'b0;
  localparam logic SEL_LO  = 1'b1;
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam logic SELA_RE = 1'b0;
  localparam logic SELA_IM = 1'b1;
  localparam int TIMEOUT_DEF = 64;
  function automatic int tmo_width(input int timeout);
    return $clog2(timeout);
  endfunction
endpackage

// File: rtl/mul_wait_watchdog.sv
// mul_wait_watchdog: counts multiplier-wait cycles and flags the last allowed one.
module mul_wait_watchdog
  import complex_mul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = tmo_width(TIMEOUT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
  end
  assign expired = run && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/complex_multiplier_controller.sv
// complex_multiplier_controller: sequences the four shared-multiplier products
// of a complex multiply and guards each multiplier wait with a watchdog.
module complex_multiplier_controller
  import complex_mul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mulReady,
  output logic ldX,
  output logic ldY,
  output logic selX,
  output logic selY,
  output logic startMul,
  output logic addBarSub,
  output logic ldRR,
  output logic ldIR,
  output logic initRR,
  output logic initIR,
  output logic selA,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state, nxt;
  logic in_start, in_wait, expired, timeout;
  assign in_start = state inside {AC_S, BD_S, AD_S, BC_S};
  assign in_wait  = state inside {AC_W, BD_W, AD_W, BC_W};
  assign timeout  = expired && !mulReady;
  mul_wait_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .rst(rst), .clear(in_start), .run(in_wait), .expired(expired)
  );
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = AC_S;
      AC_S:    nxt = AC_W;
      AC_W:    nxt = mulReady ? BD_S : timeout ? IDLE : AC_W;
      BD_S:    nxt = BD_W;
      BD_W:    nxt = mulReady ? AD_S : timeout ? IDLE : BD_W;
      AD_S:    nxt = AD_W;
      AD_W:    nxt = mulReady ? BC_S : timeout ? IDLE : AD_W;
      BC_S:    nxt = BC_W;
      BC_W:    nxt = mulReady ? DONE : timeout ? IDLE : BC_W;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end
  assign ldX       = state == LOAD;
  assign ldY       = state == LOAD;
  assign initRR    = state == LOAD;
  assign initIR    = state == LOAD;
  assign startMul  = in_start;
  assign selX      = state inside {BD_S, BD_W, BC_S, BC_W} ? SEL_LO : SEL_HI;
  assign selY      = state inside {BD_S, BD_W, AD_S, AD_W} ? SEL_LO : SEL_HI;
  assign selA      = state inside {AD_S, AD_W, BC_S, BC_W} ? SELA_IM : SELA_RE;
  assign addBarSub = state inside {BD_S, BD_W} ? OP_SUB : OP_ADD;
  // Result loads are the only Mealy outputs: they fire on the mulReady cycle.
  assign ldRR      = state inside {AC_W, BD_W} && mulReady;
  assign ldIR      = state inside {AD_W, BC_W} && mulReady;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
endmodule

// File: tb/tb_complex_multiplier_controller.sv
// tb_complex_multiplier_controller: drives the controller against a behavioural
// datapath/multiplier model and checks results, timing and strobe counts.
module tb_complex_multiplier_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic mulReady;
  logic ldX, ldY, selX, selY, startMul, addBarSub, ldRR, ldIR, initRR, initIR, selA, busy, done, err;

  complex_multiplier_controller #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mulReady(mulReady),
    .ldX(ldX), .ldY(ldY), .selX(selX), .selY(selY), .startMul(startMul),
    .addBarSub(addBarSub), .ldRR(ldRR), .ldIR(ldIR), .initRR(initRR),
    .initIR(initIR), .selA(selA), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] xin = '0, yin = '0;
  int lat = 1;
  bit stuck = 1'b0;
  logic [7:0] xreg, yreg, rr, ir, prod;
  int mcnt = 0;

  function automatic logic [7:0] nib(input logic [7:0] v, input logic lo);
    logic [3:0] n;
    n = lo ? v[3:0] : v[7:4];
    return {{4{n[3]}}, n};
  endfunction

  // Datapath and k-cycle multiplier model driven by the controller's strobes.
  assign mulReady = !stuck && (mcnt == 1);
  always @(posedge clk) begin
    if (ldX) xreg <= xin;
    if (ldY) yreg <= yin;
    if (initRR) rr <= '0;
    else if (ldRR) rr <= addBarSub ? (selA ? ir : rr) - prod : (selA ? ir : rr) + prod;
    if (initIR) ir <= '0;
    else if (ldIR) ir <= addBarSub ? (selA ? ir : rr) - prod : (selA ? ir : rr) + prod;
    if (startMul) begin
      prod <= nib(xreg, selX) * nib(yreg, selY);
      mcnt <= lat;
    end else if (mcnt != 0) mcnt <= mcnt - 1;
  end

  function automatic logic [15:0] ref_res(input logic [7:0] x, input logic [7:0] y);
    int xr, xi, yr, yi, re, im;
    logic [7:0] r8, i8;
    xr = $signed(x[7:4]); xi = $signed(x[3:0]);
    yr = $signed(y[7:4]); yi = $signed(y[3:0]);
    re = xr * yr - xi * yi;
    im = xr * yi + xi * yr;
    r8 = re[7:0]; i8 = im[7:0];
    return {r8, i8};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {ldX, ldY, selX, selY, startMul, addBarSub, ldRR, ldIR, initRR, initIR, selA, busy, done, err};
  endfunction

  int n_sm, n_rr, n_ir, n_done, n_busy, done_cyc, end_cyc, bad_ld, bad_ord;
  logic err_at1, ldx_at1;

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int k,
                        input int pulse_at, input int hold_from, input bit started);
    xin = x; yin = y; lat = k;
    n_sm = 0; n_rr = 0; n_ir = 0; n_done = 0; n_busy = 0;
    done_cyc = 0; end_cyc = 0; bad_ld = 0; bad_ord = 0;
    if (!started) begin
      start = 1'b1;
      @(posedge clk);
    end
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == pulse_at) || (hold_from != 0 && c >= hold_from);
      if (c == 1) begin err_at1 = err; ldx_at1 = ldX; end
      n_sm += int'(startMul);
      n_rr += int'(ldRR);
      n_ir += int'(ldIR);
      n_busy += int'(busy);
      if (done) begin n_done++; done_cyc = c; end
      if ((ldRR || ldIR) && !mulReady) bad_ld++;
      if (ldIR && n_rr < 2) bad_ord++;
      if (!busy) begin end_cyc = c; break; end
    end
    chk("op_terminated", end_cyc != 0, 1);
  endtask

  task automatic check_normal(input string tag, input logic [7:0] x, input logic [7:0] y, input int k);
    chk({tag, "_res"}, {rr, ir}, ref_res(x, y));
    chk({tag, "_done_cyc"}, done_cyc, 2 + 4 * (1 + k));
    chk({tag, "_busy_cycles"}, n_busy, 2 + 4 * (1 + k));
    chk({tag, "_idle_after"}, end_cyc, 3 + 4 * (1 + k));
    chk({tag, "_strobes"}, {n_sm[7:0], n_rr[7:0], n_ir[7:0], n_done[7:0]}, 32'h04020201);
    chk({tag, "_ld_gating"}, bad_ld + bad_ord, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx, ry;
    int rk;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", outs(), 0);

    run_op(8'h21, 8'h34, 1, 0, 0, 1'b0);
    check_normal("k1_2134", 8'h21, 8'h34, 1);
    chk("k1_2134_value", {rr, ir}, 16'h020B);

    run_op(8'h12, 8'h13, 1, 0, 0, 1'b0);
    check_normal("k1_1213", 8'h12, 8'h13, 1);
    chk("k1_1213_value", {rr, ir}, 16'hFB05);

    run_op(8'h21, 8'h34, 5, 0, 0, 1'b0);
    check_normal("k5", 8'h21, 8'h34, 5);

    run_op(8'h57, 8'h63, 8, 0, 0, 1'b0);
    check_normal("k8_boundary", 8'h57, 8'h63, 8);

    for (int i = 0; i < 6; i++) begin
      rx = {1'b0, 3'($urandom_range(0, 7)), 1'b0, 3'($urandom_range(0, 7))};
      ry = {1'b0, 3'($urandom_range(0, 7)), 1'b0, 3'($urandom_range(0, 7))};
      rk = $urandom_range(1, 4);
      run_op(rx, ry, rk, 0, 0, 1'b0);
      check_normal("random", rx, ry, rk);
    end

    stuck = 1'b1;
    run_op(8'h21, 8'h34, 1, 0, 0, 1'b0);
    chk("tmo_idle_cyc", end_cyc, 11);
    chk("tmo_busy_cycles", n_busy, 10);
    chk("tmo_no_load", n_rr + n_ir, 0);
    chk("tmo_no_done", n_done, 0);
    chk("tmo_startmul", n_sm, 1);
    chk("tmo_err_set", err, 1);
    @(negedge clk);
    chk("tmo_err_sticky", err, 1);
    stuck = 1'b0;
    run_op(8'h21, 8'h34, 2, 0, 0, 1'b0);
    chk("tmo_err_cleared", err_at1, 0);
    check_normal("after_tmo", 8'h21, 8'h34, 2);

    xin = 8'h12; yin = 8'h13; lat = 5; n_done = 0;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_done += int'(done);
    end
    #2 rst = 1'b0;
    #1 chk("rst_async_outputs", outs(), 0);
    @(negedge clk);
    chk("rst_held_outputs", outs(), 0);
    chk("rst_no_done", n_done, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", outs(), 0);
    run_op(8'h21, 8'h34, 1, 0, 0, 1'b0);
    check_normal("after_rst", 8'h21, 8'h34, 1);
    chk("after_rst_value", {rr, ir}, 16'h020B);

    run_op(8'h34, 8'h25, 3, 11, 14, 1'b0);
    check_normal("busy_start", 8'h34, 8'h25, 3);
    run_op(8'h21, 8'h34, 1, 0, 0, 1'b1);
    chk("b2b_load_first", ldx_at1, 1);
    check_normal("b2b", 8'h21, 8'h34, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
